alu_cmd_arbiter: RTL and testbench
==================================

Name: alu_cmd_arbiter

Overview:
- Round-robin arbiter that shares one state_based ALU controller between N_REQ requesters (cores/DMA ports).
- Each requester offers a 12-bit command (op[11:9], addr1[8:6], addr2[5:3], addr3[2:0]) with a valid/ready handshake.
- The arbiter issues exactly one command at a time as a single-cycle syscall and waits for controller completion.
- It then returns the result (register 7) to the owning requester.
- An optional lock keeps a CAS-based read-modify-write sequence atomic across several commands.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CMD_W, 12, command width.
- DATA_W, 32, result width.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with CMD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester command valid.
- req_cmd  in  N_REQ*CMD_W  packed commands; requester i occupies bits [i*CMD_W +: CMD_W].
- req_lock  in  N_REQ  request to keep ownership after this command.
- req_ready  out  N_REQ  one-hot accept strobe.
- resp_valid  out  N_REQ  one-hot, single-cycle completion strobe.
- resp_data  out  DATA_W  result captured from ctrl_result.
- resp_err  out  1  timeout flag, qualified by resp_valid.
- ctrl_command  out  CMD_W  command to the controller.
- ctrl_syscall  out  1  single-cycle RUN pulse.
- ctrl_done  in  1  single-cycle pulse when the controller returns to IDLE.
- ctrl_result  in  DATA_W  controller register 7.
- grant_id  out  $clog2(N_REQ)  current owner index.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, rst_n.
- Reset values:
  - All outputs 0.
  - State IDLE, rr_ptr 0, locked 0, owner 0, timeout counter 0.
  - Reset mid-transaction aborts the transaction. No response is generated; ctrl_syscall deasserts immediately.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE:
  - If locked=1, only the owner is eligible. Otherwise search req_valid starting at rr_ptr, wrapping modulo N_REQ.
  - Winner w: req_ready[w]=1 combinationally in the same cycle.
  - Latch cmd_q=req_cmd[w], owner=w, lock_q=req_lock[w]; next state ISSUE.
  - No valid requester: stay in IDLE.
  - Under lock with owner not valid: stay in IDLE and grant no one; lock is held.
- ISSUE:
  - ctrl_syscall=1 and ctrl_command=cmd_q for exactly one cycle; next state WAIT_DONE.
  - ctrl_command holds cmd_q through WAIT_DONE.
- WAIT_DONE:
  - On ctrl_done: resp_data<=ctrl_result, resp_err<=0; next state RESP.
  - ctrl_done seen in IDLE or ISSUE is ignored.
- RESP:
  - resp_valid[owner]=1 for one cycle.
  - locked<=lock_q.
  - rr_ptr<=(owner+1) mod N_REQ if lock_q=0; rr_ptr is unchanged if lock_q=1.
  - Next state IDLE.
- Latency: accept at cycle T, syscall at T+1. resp_valid appears on the cycle after the ctrl_done edge is sampled. Minimum accept-to-accept spacing is 4 cycles plus controller latency.
- grant_id=owner; it is valid whenever busy=1.
- resp_data holds its value until the next capture.
- Simultaneous requests: the lowest index at or after rr_ptr wins. Changing req_valid or req_cmd while not ready is legal; the value is sampled only at accept.
- Wrap-around: rr_ptr=N_REQ-1 followed by a grant to N_REQ-1 gives rr_ptr=0.
- Locked owner releases the lock by issuing a command with req_lock=0. The lock clears at that command's RESP.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_DONE and clears on entry.
  - If the counter reaches TIMEOUT_CYCLES without ctrl_done: resp_err=1, resp_data=0, next state RESP.
  - The lock is forced clear (locked<=0), and rr_ptr advances as if lock_q=0.
  - A late ctrl_done arriving after the timeout is ignored.
- Not defined: no counter exists, WAIT_DONE waits indefinitely, and resp_err is tied to 0.

Test Plan:
- Single request, requester 2 cmd 12'h0D1, controller done 3 cycles after syscall with result 32'h0000_0005 -> req_ready=4'b0100 at T, one syscall at T+1 carrying 12'h0D1, resp_valid=4'b0100 with resp_data=5, rr_ptr=3.
- All four requesters valid continuously from reset -> grant order 0,1,2,3,0; exactly one syscall per grant; each response goes only to its owner.
- Requester 1 issues CAS 12'hE4A with req_lock=1, then 12'h052 with lock=0, while requester 0 stays valid -> both requester-1 commands are granted back-to-back before requester 0; rr_ptr=2 after the release.
- Reset asserted in WAIT_DONE while requester 3 is owner -> all outputs 0 asynchronously; no resp_valid; after release, requester 0 is granted first.
- ctrl_done pulsed during IDLE and ISSUE -> no response and no state change; the response is produced only by a later done in WAIT_DONE.
- CMD_TIMEOUT_EN, TIMEOUT_CYCLES=8, controller never completes -> resp_valid with resp_err=1 and resp_data=0 after 8 WAIT_DONE cycles; a lock from that command is cleared; a later stray ctrl_done is ignored.

Source files
------------

// File: rtl/alu_cmd_arbiter.sv
// Round-robin arbiter sharing one ALU controller between N_REQ requesters, with an optional ownership lock.
// Latency: accept at T, syscall at T+1, resp_valid one cycle after ctrl_done is sampled in WAIT_DONE.
// Backpressure: req_ready is a one-hot, same-cycle grant; losers and all requesters outside IDLE simply wait.
// Optional macro CMD_TIMEOUT_EN: adds a WAIT_DONE watchdog that returns resp_err=1 after TIMEOUT_CYCLES.
module alu_cmd_arbiter #(
    parameter int N_REQ          = 4,
    parameter int CMD_W          = 12,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*CMD_W-1:0]        req_cmd,
    input  logic [N_REQ-1:0]              req_lock,
    output logic [N_REQ-1:0]              req_ready,
    output logic [N_REQ-1:0]              resp_valid,
    output logic [DATA_W-1:0]             resp_data,
    output logic                          resp_err,
    output logic [CMD_W-1:0]              ctrl_command,
    output logic                          ctrl_syscall,
    input  logic                          ctrl_done,
    input  logic [DATA_W-1:0]             ctrl_result,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          busy
);

    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic             locked;
    logic             lock_q;
    logic [CMD_W-1:0] cmd_q;

    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W:0]   scan;
    logic [IDX_W-1:0] next_owner;
    logic             to_hit;

    // Winner search: locked owner only, else first valid requester at or after rr_ptr.
    // Scanning offsets from high to low lets the lowest offset overwrite and win.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        scan    = '0;
        if (locked) begin
            win_vld = req_valid[owner];
            win_idx = owner;
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                scan = {1'b0, rr_ptr} + (IDX_W+1)'(k);
                if (scan >= (IDX_W+1)'(N_REQ)) begin
                    scan = scan - (IDX_W+1)'(N_REQ);
                end
                if (req_valid[scan[IDX_W-1:0]]) begin
                    win_vld = 1'b1;
                    win_idx = scan[IDX_W-1:0];
                end
            end
        end
    end

    assign next_owner = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

    // Grant strobe is masked by rst_n so every output reads 0 while reset is held.
    assign req_ready    = (rst_n && state == S_IDLE && win_vld)
                          ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;
    assign resp_valid   = (state == S_RESP) ? ({{(N_REQ-1){1'b0}}, 1'b1} << owner) : '0;
    assign ctrl_syscall = (state == S_ISSUE);
    assign ctrl_command = (state == S_ISSUE || state == S_WAIT) ? cmd_q : '0;
    assign grant_id     = owner;
    assign busy         = (state != S_IDLE);

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    // The counter value equals the number of WAIT_DONE cycles already completed.
    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared while issuing, counts each WAIT_DONE cycle without completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == S_ISSUE) begin
            to_cnt <= '0;
        end else if (state == S_WAIT && !ctrl_done && !to_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    // Watchdog absent: WAIT_DONE waits for ctrl_done indefinitely. The parameter is
    // kept so both builds share one port/parameter list.
    assign to_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    // Main sequencer: accept, issue one syscall, wait for completion, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            locked    <= 1'b0;
            lock_q    <= 1'b0;
            cmd_q     <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        cmd_q  <= req_cmd[win_idx*CMD_W +: CMD_W];
                        owner  <= win_idx;
                        lock_q <= req_lock[win_idx];
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the same cycle as the timeout still counts as on time.
                    if (ctrl_done) begin
                        resp_data <= ctrl_result;
                        resp_err  <= 1'b0;
                        state     <= S_RESP;
                    end else if (to_hit) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                default: begin
                    // A timed-out command never keeps the lock, so a hung sequence cannot starve others.
                    locked <= lock_q & ~resp_err;
                    if (!lock_q || resp_err) begin
                        rr_ptr <= next_owner;
                    end
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_arbiter.sv
module tb_alu_cmd_arbiter;

    localparam int N      = 4;
    localparam int CW     = 12;
    localparam int DW     = 32;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*CW-1:0] req_cmd;
    logic [N-1:0]    req_lock;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;
    logic            resp_err;
    logic [CW-1:0]   ctrl_command;
    logic            ctrl_syscall;
    logic            ctrl_done;
    logic [DW-1:0]   ctrl_result;
    logic [1:0]      grant_id;
    logic            busy;

    logic [CW-1:0]   cmd_arr [N];

    int errors  = 0;
    int checks  = 0;
    int sys_cnt = 0;
    int resp_cnt = 0;
    int r0;

    alu_cmd_arbiter #(
        .N_REQ(N), .CMD_W(CW), .DATA_W(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_lock(req_lock),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .ctrl_command(ctrl_command), .ctrl_syscall(ctrl_syscall),
        .ctrl_done(ctrl_done), .ctrl_result(ctrl_result),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb req_cmd = {cmd_arr[3], cmd_arr[2], cmd_arr[1], cmd_arr[0]};

    // Mid-cycle event counters for syscall pulses and response strobes.
    always @(negedge clk) begin
        if (ctrl_syscall) sys_cnt++;
        if (resp_valid != '0) resp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req_ready"},  32'(req_ready),    0);
        check({tag, " resp_valid"}, 32'(resp_valid),   0);
        check({tag, " resp_data"},  resp_data,         0);
        check({tag, " resp_err"},   32'(resp_err),     0);
        check({tag, " command"},    32'(ctrl_command), 0);
        check({tag, " syscall"},    32'(ctrl_syscall), 0);
        check({tag, " grant_id"},   32'(grant_id),     0);
        check({tag, " busy"},       32'(busy),         0);
    endtask

    // One full transaction from an IDLE cycle; drop clears the owner's valid after accept.
    task automatic serve(input int own, input logic [11:0] cmd, input logic [31:0] res,
                         input int dly, input bit drop);
        int s0, q0;
        #1;
        check("grant ready", 32'(req_ready), 32'(1 << own));
        s0 = sys_cnt;
        q0 = resp_cnt;
        tick();
        if (drop) req_valid[own] = 1'b0;
        check("issue syscall", 32'(ctrl_syscall), 1);
        check("issue command", 32'(ctrl_command), 32'(cmd));
        check("issue grant_id", 32'(grant_id), 32'(own));
        check("issue ready", 32'(req_ready), 0);
        tick();
        check("wait syscall", 32'(ctrl_syscall), 0);
        check("wait command held", 32'(ctrl_command), 32'(cmd));
        repeat (dly) tick();
        check("wait no resp", 32'(resp_valid), 0);
        ctrl_done = 1'b1;
        ctrl_result = res;
        tick();
        ctrl_done = 1'b0;
        ctrl_result = '0;
        check("resp valid", 32'(resp_valid), 32'(1 << own));
        check("resp data", resp_data, res);
        check("resp err", 32'(resp_err), 0);
        tick();
        check("post resp valid", 32'(resp_valid), 0);
        check("post busy", 32'(busy), 0);
        check("resp data held", resp_data, res);
        check("one syscall", 32'(sys_cnt - s0), 1);
        check("one response", 32'(resp_cnt - q0), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_lock = '0;
        ctrl_done = 1'b0;
        ctrl_result = '0;
        for (int i = 0; i < N; i++) cmd_arr[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'hF;
        #1;
        check_all_zero("reset");
        req_valid = '0;
        rst_n = 1'b1;
        tick();

        // Single request from requester 2, done 3 cycles after syscall.
        cmd_arr[2] = 12'h0D1;
        req_valid = 4'b0100;
        serve(2, 12'h0D1, 32'h5, 3, 1);
        // rr_ptr is now 3, so requester 3 beats requester 0; granting 3 wraps to 0.
        cmd_arr[0] = 12'h010;
        cmd_arr[3] = 12'h333;
        req_valid = 4'b1001;
        serve(3, 12'h333, 32'h33, 1, 1);
        serve(0, 12'h010, 32'h10, 1, 1);

        // All requesters valid from reset: order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < N; i++) cmd_arr[i] = 12'h100 + 12'(i * 'h11);
        req_valid = 4'hF;
        serve(0, 12'h100, 32'hA0, 1, 0);
        serve(1, 12'h111, 32'hA1, 1, 0);
        serve(2, 12'h122, 32'hA2, 1, 0);
        serve(3, 12'h133, 32'hA3, 1, 0);
        serve(0, 12'h100, 32'hA4, 1, 0);

        // Locked CAS sequence from requester 1 while 0 and 2 stay valid (rr_ptr=1).
        req_valid = 4'b0111;
        cmd_arr[1] = 12'hE4A;
        req_lock[1] = 1'b1;
        serve(1, 12'hE4A, 32'h1, 2, 0);
        req_valid[1] = 1'b0;
        #1;
        check("lock hold ready", 32'(req_ready), 0);
        tick();
        check("lock hold busy", 32'(busy), 0);
        check("lock hold ready2", 32'(req_ready), 0);
        cmd_arr[1] = 12'h052;
        req_lock[1] = 1'b0;
        req_valid[1] = 1'b1;
        serve(1, 12'h052, 32'h2, 1, 1);
        // Released with rr_ptr=2: requester 2 wins over 0.
        serve(2, 12'h122, 32'h3, 1, 1);
        serve(0, 12'h100, 32'h4, 1, 1);

        // Reset during WAIT_DONE with requester 3 as owner.
        cmd_arr[3] = 12'h3C3;
        req_valid = 4'b1000;
        #1;
        check("r4 ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        check("r4 owner", 32'(grant_id), 3);
        r0 = resp_cnt;
        #2;
        rst_n = 1'b0;
        req_valid = 4'b1000;
        ctrl_done = 1'b1;
        ctrl_result = 32'h99;
        #1;
        check_all_zero("midreset");
        tick();
        ctrl_done = 1'b0;
        ctrl_result = '0;
        rst_n = 1'b1;
        check("no resp in reset", 32'(resp_cnt - r0), 0);
        req_valid = 4'b1001;
        serve(0, 12'h100, 32'h44, 1, 1);
        req_valid = '0;

        // Stray done in IDLE and ISSUE is ignored.
        r0 = resp_cnt;
        ctrl_done = 1'b1;
        ctrl_result = 32'hDEAD;
        tick();
        ctrl_done = 1'b0;
        check("idle done resp", 32'(resp_valid), 0);
        check("idle done busy", 32'(busy), 0);
        check("idle done data", resp_data, 32'h44);
        cmd_arr[2] = 12'h2B3;
        req_valid = 4'b0100;
        #1;
        check("t5 ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        ctrl_done = 1'b1;
        ctrl_result = 32'hBAD;
        tick();
        ctrl_done = 1'b0;
        check("issue done busy", 32'(busy), 1);
        check("issue done resp", 32'(resp_valid), 0);
        tick();
        check("still waiting", 32'(resp_valid), 0);
        check("stray no resp", 32'(resp_cnt - r0), 0);
        ctrl_done = 1'b1;
        ctrl_result = 32'h77;
        tick();
        ctrl_done = 1'b0;
        check("late done resp", 32'(resp_valid), 32'h4);
        check("late done data", resp_data, 32'h77);
        tick();

`ifdef CMD_TIMEOUT_EN
        // Controller never completes: timeout after 8 WAIT_DONE cycles clears the lock.
        cmd_arr[1] = 12'hE00;
        req_lock[1] = 1'b1;
        req_valid = 4'b0010;
        #1;
        check("to ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        repeat (8) tick();
        check("to pending", 32'(resp_valid), 0);
        check("to busy", 32'(busy), 1);
        tick();
        check("to resp", 32'(resp_valid), 32'h2);
        check("to err", 32'(resp_err), 1);
        check("to data", resp_data, 0);
        tick();
        r0 = resp_cnt;
        ctrl_done = 1'b1;
        ctrl_result = 32'h55;
        tick();
        ctrl_done = 1'b0;
        check("to stray resp", 32'(resp_cnt - r0), 0);
        check("to stray data", resp_data, 0);
        req_lock[1] = 1'b0;
        req_valid = 4'b0011;
        #1;
        check("to lock cleared", 32'(req_ready), 32'h1);
        req_valid = '0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
